gerador_operandos_somador: RTL and testbench

- Initiator side of the 4-operand summing handshake (inicio / valor / pronto / soma / overflow).
- Holds a small operand buffer that host logic loads through a write port. On `go`, it pulses `inicio`, presents one operand on `valor` per cycle, then waits for `pronto` and captures `soma` and `overflow`.
- Independently computes the expected sum and flags any mismatch. Used as the stimulus/collection engine in front of the summing state machine.

---
 rtl/somatorio_pkg.sv | 25 ++
 rtl/buffer_operandos.sv | 34 +++
 rtl/gerador_operandos_somador.sv | 134 +++++++++++++
 tb/tb_gerador_operandos_somador.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/somatorio_pkg.sv
// Shared definitions for the operand generator and the summing state machine.
// Holds the default widths, the generator state encoding and the overflow helper.
// Pure declarations: no logic, no latency, no flow control.
package somatorio_pkg;

  localparam int DEF_WIDTH = 6;
  localparam int DEF_N_OPS = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_FEED  = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } estado_t;

  // Two's complement add overflow: operands share a sign and the sum does not.
  function automatic logic ovf_soma(input logic [DEF_WIDTH-1:0] a,
                                    input logic [DEF_WIDTH-1:0] b);
    logic [DEF_WIDTH-1:0] s;
    s = a + b;
    return (a[DEF_WIDTH-1] == b[DEF_WIDTH-1]) && (s[DEF_WIDTH-1] != a[DEF_WIDTH-1]);
  endfunction

endpackage

// File: rtl/buffer_operandos.sv
// N_OPS x WIDTH operand register file; write accepted only while the generator is idle.
// Read is combinational (zero latency); write lands at the clock edge.
// No backpressure: writes outside idle are silently dropped.
module buffer_operandos
  import somatorio_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_OPS = DEF_N_OPS,
  parameter int IDX_W = (N_OPS > 1) ? $clog2(N_OPS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ocioso,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [N_OPS];

  // Slot storage: cleared by reset, loaded only while the generator is idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_OPS; i++) mem[i] <= '0;
    end else if (ocioso && wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/gerador_operandos_somador.sv
// Initiator of the 4-operand summing handshake: pulses inicio, feeds operands, collects soma.
// Latency: go sampled -> done in N_OPS+3 cycles minimum; WAIT bounded by TIMEOUT cycles.
// No backpressure on the host: wr_en and go are ignored while busy.
module gerador_operandos_somador
  import somatorio_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int N_OPS   = DEF_N_OPS,
  parameter int TIMEOUT = 8,
  parameter int IDX_W   = (N_OPS > 1) ? $clog2(N_OPS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             go,
  output logic             busy,
  output logic             inicio,
  output logic [WIDTH-1:0] valor,
  input  logic             pronto,
  input  logic [WIDTH-1:0] soma_in,
  input  logic             overflow_in,
  output logic [WIDTH-1:0] resultado,
  output logic             ovf,
  output logic             done,
  output logic             erro,
  output logic             mismatch
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_OPS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  estado_t          estado;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic [TMR_W-1:0] timer;
  logic [WIDTH-1:0] soma_local;
  logic             ocioso;

  assign ocioso = (estado == S_IDLE);
  assign busy   = !ocioso;

  // valor is registered, so the buffer is read one slot ahead of the operand on the wire.
  assign rd_addr = (estado == S_FEED) ? idx + IDX_W'(1) : '0;

  buffer_operandos #(
    .WIDTH (WIDTH),
    .N_OPS (N_OPS),
    .IDX_W (IDX_W)
  ) u_buffer (
    .clk     (clk),
    .reset   (reset),
    .ocioso  (ocioso),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Transaction FSM with registered handshake outputs, timer and local reference sum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado     <= S_IDLE;
      idx        <= '0;
      timer      <= '0;
      soma_local <= '0;
      inicio     <= 1'b0;
      valor      <= '0;
      done       <= 1'b0;
      resultado  <= '0;
      ovf        <= 1'b0;
      erro       <= 1'b0;
      mismatch   <= 1'b0;
    end else begin
      inicio <= 1'b0;
      done   <= 1'b0;
      case (estado)
        S_IDLE: begin
          valor <= '0;
          if (go) begin
            estado   <= S_START;
            inicio   <= 1'b1;
            erro     <= 1'b0;
            mismatch <= 1'b0;
          end
        end
        S_START: begin
          idx        <= '0;
          soma_local <= '0;
          valor      <= rd_data;
          estado     <= S_FEED;
        end
        S_FEED: begin
          // valor holds buf[idx] this cycle; the sum wraps modulo 2^WIDTH.
          soma_local <= soma_local + valor;
          if (idx == IDX_LAST) begin
            valor  <= '0;
            timer  <= '0;
            estado <= S_WAIT;
          end else begin
            idx   <= idx + IDX_W'(1);
            valor <= rd_data;
          end
        end
        S_WAIT: begin
          if (pronto) begin
            resultado <= soma_in;
            ovf       <= overflow_in;
            mismatch  <= (soma_in != soma_local);
            done      <= 1'b1;
            estado    <= S_DONE;
          end else if (timer == TMR_LAST) begin
            erro   <= 1'b1;
            done   <= 1'b1;
            estado <= S_DONE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        S_DONE: begin
          estado <= S_IDLE;
        end
        default: begin
          estado <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gerador_operandos_somador.sv
// Directed bench for gerador_operandos_somador with an in-bench summer responder.
// Outcomes are queued at go and popped by an independent monitor on each done pulse.
// Cycle-level handshake timing is checked inline while the transaction runs.
module tb_gerador_operandos_somador;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [5:0] wr_data;
  logic       go;
  logic       busy;
  logic       inicio;
  logic [5:0] valor;
  logic       pronto;
  logic [5:0] soma_in;
  logic       overflow_in;
  logic [5:0] resultado;
  logic       ovf;
  logic       done;
  logic       erro;
  logic       mismatch;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [5:0] res;
    logic       ovf;
    logic       erro;
    logic       mism;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  gerador_operandos_somador dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .go          (go),
    .busy        (busy),
    .inicio      (inicio),
    .valor       (valor),
    .pronto      (pronto),
    .soma_in     (soma_in),
    .overflow_in (overflow_in),
    .resultado   (resultado),
    .ovf         (ovf),
    .done        (done),
    .erro        (erro),
    .mismatch    (mismatch)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest queued outcome.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected_done: done pulse with empty queue (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_resultado", resultado, e.res);
        chk("sb_ovf", ovf, e.ovf);
        chk("sb_erro", erro, e.erro);
        chk("sb_mismatch", mismatch, e.mism);
      end
    end
  end

  // One transaction: optional load (last write shares the go cycle), feed checks, summer reply.
  task automatic txn(input logic [3:0][5:0] o, input bit do_load, input bit timeout_mode,
                     input bit poke, input logic [5:0] rsp, input logic rsp_ovf, input exp_t e);
    int nwait;
    if (do_load) begin
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = 2'(k); wr_data = o[k];
      end
    end
    sb.push_back(e);
    @(posedge clk); #1;
    wr_en = do_load; wr_addr = 2'd3; wr_data = o[3]; go = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0; go = 1'b0;
    @(negedge clk);
    chk("start_inicio", inicio, 1);
    chk("start_valor", valor, 0);
    chk("start_busy", busy, 1);
    chk("start_erro_clr", erro, 0);
    chk("start_mismatch_clr", mismatch, 0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      pronto = timeout_mode;
      if (poke && k == 0) begin
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 6'd7; go = 1'b1;
      end else begin
        wr_en = 1'b0; go = 1'b0;
      end
      @(negedge clk);
      chk("feed_inicio", inicio, 0);
      chk($sformatf("feed_valor%0d", k), valor, o[k]);
    end
    @(posedge clk); #1;
    wr_en = 1'b0; go = 1'b0;
    if (!timeout_mode) begin
      pronto = 1'b1; soma_in = rsp; overflow_in = rsp_ovf;
    end else begin
      pronto = 1'b0;
    end
    @(negedge clk);
    chk("wait_done_low", done, 0);
    nwait = timeout_mode ? 8 : 1;
    for (int i = 1; i < nwait; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("timeout_done_low", done, 0);
    end
    @(posedge clk); #1;
    pronto = 1'b0; soma_in = '0; overflow_in = 1'b0;
    @(negedge clk);
    chk("done_pulse", done, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("after_busy", busy, 0);
    chk("after_inicio", inicio, 0);
    chk("after_done", done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; go = 1'b0;
    pronto = 1'b0; soma_in = '0; overflow_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_inicio", inicio, 0);
    chk("rst_valor", valor, 0);
    chk("rst_done", done, 0);
    chk("rst_erro", erro, 0);
    chk("rst_mismatch", mismatch, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_resultado", resultado, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 1+2+3+4 = 10, correct summer reply.
    txn({6'd4, 6'd3, 6'd2, 6'd1}, 1, 0, 0, 6'd10, 1'b0, '{res: 6'd10, ovf: 1'b0, erro: 1'b0, mism: 1'b0});
    // 20+20 = 40 = 6'b101000 (-24): summer reports overflow, sum agrees.
    txn({6'd0, 6'd0, 6'd20, 6'd20}, 1, 0, 0, 6'b101000, 1'b1, '{res: 6'b101000, ovf: 1'b1, erro: 1'b0, mism: 1'b0});
    // Wrong summer reply 11 for 1..4 raises mismatch.
    txn({6'd4, 6'd3, 6'd2, 6'd1}, 1, 0, 0, 6'd11, 1'b0, '{res: 6'd11, ovf: 1'b0, erro: 1'b0, mism: 1'b1});
    repeat (3) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("mismatch_sticky", mismatch, 1);
    end
    // Summer silent after FEED (pronto only high during FEED): timeout, resultado kept at 11.
    txn({6'd4, 6'd3, 6'd2, 6'd1}, 0, 1, 0, 6'd0, 1'b0, '{res: 6'd11, ovf: 1'b0, erro: 1'b1, mism: 1'b0});
    @(posedge clk); #1;
    @(negedge clk);
    chk("erro_sticky", erro, 1);
    // Write of 7 to slot 0 and a second go while busy are both ignored.
    txn({6'd8, 6'd7, 6'd6, 6'd5}, 1, 0, 1, 6'd26, 1'b0, '{res: 6'd26, ovf: 1'b0, erro: 1'b0, mism: 1'b0});
    txn({6'd8, 6'd7, 6'd6, 6'd5}, 0, 0, 0, 6'd26, 1'b0, '{res: 6'd26, ovf: 1'b0, erro: 1'b0, mism: 1'b0});

    // Reset in the FEED cycle presenting slot 2.
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      wr_en = 1'b1; wr_addr = 2'(k); wr_data = 6'(k + 1);
    end
    @(posedge clk); #1;
    wr_en = 1'b0; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("pre_reset_valor", valor, 3);
    reset = 1'b1;
    #1;
    chk("midrst_inicio", inicio, 0);
    chk("midrst_valor", valor, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_resultado", resultado, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    // Cleared buffer: fresh go feeds zeros and collects 0.
    txn({6'd0, 6'd0, 6'd0, 6'd0}, 0, 0, 0, 6'd0, 1'b0, '{res: 6'd0, ovf: 1'b0, erro: 1'b0, mism: 1'b0});

    repeat (2) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
